// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and strobe indices shared by the ALU op sequencer
package alu_seq_pkg;
  localparam logic [3:0] OP_CLR = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [3:0] OP_SHR = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_AND = 4'd7;
  localparam logic [3:0] OP_OR  = 4'd8;
  localparam logic [3:0] OP_NOT = 4'd9;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_EXEC, ST_WAIT, ST_ERR, ST_DONE} state_t;
  localparam int IDX_C8  = 0;
  localparam int IDX_C9  = 1;
  localparam int IDX_C13 = 2;
  localparam int IDX_C15 = 3;
  localparam int IDX_C16 = 4;
  localparam int IDX_C17 = 5;
  localparam int IDX_C18 = 6;
  localparam int IDX_C19 = 7;
  localparam int IDX_C20 = 8;
  localparam int IDX_C21 = 9;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: opcode to one-hot strobe vector and operand/shift/legality flags
module alu_op_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] cmd_op,
  output logic [9:0] strobe_vec,
  output logic       needs_br,
  output logic       is_shift,
  output logic       legal
);
  always_comb begin
    strobe_vec = '0;
    strobe_vec[IDX_C8]  = cmd_op == OP_CLR;
    strobe_vec[IDX_C9]  = cmd_op == OP_ADD;
    strobe_vec[IDX_C13] = cmd_op == OP_SUB;
    strobe_vec[IDX_C15] = cmd_op == OP_MUL;
    strobe_vec[IDX_C16] = cmd_op == OP_DIV;
    strobe_vec[IDX_C17] = cmd_op == OP_SHR;
    strobe_vec[IDX_C18] = cmd_op == OP_SHL;
    strobe_vec[IDX_C19] = cmd_op == OP_AND;
    strobe_vec[IDX_C20] = cmd_op == OP_OR;
    strobe_vec[IDX_C21] = cmd_op == OP_NOT;
  end
  assign needs_br = cmd_op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR};
  assign is_shift = cmd_op == OP_SHR || cmd_op == OP_SHL;
  assign legal    = cmd_op <= OP_NOT;
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts ALU commands, loads BR and issues registered one-hot control strobes
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [15:0]      cmd_operand,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             br_load,
  output logic [15:0]      br_data,
  output logic             C8,
  output logic             C9,
  output logic             C13,
  output logic             C15,
  output logic             C16,
  output logic             C17,
  output logic             C18,
  output logic             C19,
  output logic             C20,
  output logic             C21,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  state_t state, nxt;
  logic [9:0] dec_vec, vec_q, strb_q;
  logic dec_nb, dec_shift, dec_legal, shift_q, accept;
  logic [CNT_W-1:0] cnt_q;
  logic [SW-1:0] wait_q;
  alu_op_decode u_dec (
    .cmd_op    (cmd_op),
    .strobe_vec(dec_vec),
    .needs_br  (dec_nb),
    .is_shift  (dec_shift),
    .legal     (dec_legal)
  );
  assign cmd_ready = state == ST_IDLE && !rst;
  assign accept = cmd_valid && cmd_ready;
  assign {C21, C20, C19, C18, C17, C16, C15, C13, C9, C8} = strb_q;
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: nxt = !accept ? ST_IDLE
                   : (!dec_legal || (cmd_op == OP_DIV && cmd_operand == '0)) ? ST_ERR
                   : dec_nb ? ST_LOAD
                   : (dec_shift && cmd_count == '0) ? ST_DONE : ST_EXEC;
      ST_LOAD: nxt = ST_EXEC;
      ST_EXEC: nxt = shift_q && cnt_q > CNT_W'(1) ? ST_EXEC : ST_WAIT;
      ST_WAIT: nxt = wait_q == '0 ? ST_DONE : ST_WAIT;
      ST_ERR:  nxt = ST_DONE;
      default: nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      vec_q   <= '0;
      strb_q  <= '0;
      shift_q <= 1'b0;
      cnt_q   <= '0;
      wait_q  <= SW'(SETTLE - 1);
      br_load <= 1'b0;
      br_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= nxt;
      strb_q  <= nxt == ST_EXEC ? (accept ? dec_vec : vec_q) : '0;
      br_load <= nxt == ST_LOAD;
      busy    <= nxt != ST_IDLE;
      done    <= nxt == ST_DONE;
      err     <= nxt == ST_ERR || (err && !accept);
      wait_q  <= state == ST_WAIT ? wait_q - 1'b1 : SW'(SETTLE - 1);
      cnt_q   <= accept ? (dec_shift ? cmd_count : '0)
               : (state == ST_EXEC && shift_q) ? cnt_q - 1'b1 : cnt_q;
      if (accept) begin
        vec_q   <= dec_vec;
        shift_q <= dec_shift;
        br_data <= cmd_operand;
      end
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and random commands checked against a command-level timing and accumulator model
module tb_alu_op_sequencer;
  localparam int SETTLE = 1;
  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_ready, br_load, busy, done, err;
  logic [3:0] cmd_op, cmd_count;
  logic [15:0] cmd_operand, br_data;
  logic C8, C9, C13, C15, C16, C17, C18, C19, C20, C21;
  logic [9:0] strb;
  logic [15:0] acc_m = '0, br_m = '0, acc_ref = '0;
  int n_cmp = 0, n_bad = 0;
  bit mon_on = 1'b0;
  alu_op_sequencer #(.CNT_W(4), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_operand(cmd_operand), .cmd_count(cmd_count),
    .br_load(br_load), .br_data(br_data),
    .C8(C8), .C9(C9), .C13(C13), .C15(C15), .C16(C16), .C17(C17),
    .C18(C18), .C19(C19), .C20(C20), .C21(C21),
    .busy(busy), .done(done), .err(err)
  );
  assign strb = {C21, C20, C19, C18, C17, C16, C15, C13, C9, C8};
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (br_load) br_m <= br_data;
    if (C8) acc_m <= '0;
    else if (C9) acc_m <= acc_m + br_m;
    else if (C13) acc_m <= acc_m - br_m;
    else if (C15) acc_m <= acc_m * br_m;
    else if (C16) acc_m <= acc_m / br_m;
    else if (C17) acc_m <= acc_m >> 1;
    else if (C18) acc_m <= acc_m << 1;
    else if (C19) acc_m <= acc_m & br_m;
    else if (C20) acc_m <= acc_m | br_m;
    else if (C21) acc_m <= ~acc_m;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (mon_on) chk("onehot", 32'($countones(strb) <= 1), 32'd1);
  task automatic run_cmd(input logic [3:0] op, input logic [15:0] opr, input logic [3:0] cnt, input bit hold);
    bit e, nb, sh;
    int lat, s0, s1, w;
    logic [9:0] sv;
    logic [15:0] exp, got;
    e   = op > 4'd9 || (op == 4'd4 && opr == 16'd0);
    nb  = !e && op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8};
    sh  = !e && (op == 4'd5 || op == 4'd6);
    lat = e ? 2 : nb ? 3 + SETTLE : sh ? (cnt == 0 ? 1 : int'(cnt) + 1 + SETTLE) : 2 + SETTLE;
    s0  = e ? 1 : nb ? 2 : 1;
    s1  = e ? 0 : nb ? 2 : sh ? int'(cnt) : 1;
    w = 0;
    while (!cmd_ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_operand = opr;
    cmd_count = cnt;
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    cmd_op = 4'($urandom);
    cmd_operand = 16'($urandom);
    cmd_count = 4'($urandom);
    for (int k = 1; k <= lat + 1; k++) begin
      sv = (k >= s0 && k <= s1) ? 10'd1 << op : 10'd0;
      exp = {1'b0, k == lat + 1, nb && k == 1, sv, k <= lat, k == lat, e};
      got = {1'b0, cmd_ready, br_load, strb, busy, done, err};
      chk($sformatf("op%0d_k%0d", op, k), 32'(got), 32'(exp));
      if (k == lat) chk("br_data", 32'(br_data), 32'(opr));
      if (k <= lat) @(negedge clk);
    end
    if (!e)
      case (op)
        4'd0: acc_ref = '0;
        4'd1: acc_ref = acc_ref + opr;
        4'd2: acc_ref = acc_ref - opr;
        4'd3: acc_ref = acc_ref * opr;
        4'd4: acc_ref = acc_ref / opr;
        4'd5: acc_ref = acc_ref >> cnt;
        4'd6: acc_ref = acc_ref << cnt;
        4'd7: acc_ref = acc_ref & opr;
        4'd8: acc_ref = acc_ref | opr;
        default: acc_ref = ~acc_ref;
      endcase
    chk("acc", 32'(acc_m), 32'(acc_ref));
  endtask
  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_operand = '0;
    cmd_count = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset", 32'({cmd_ready, br_load, strb, busy, done, err, br_data}), 32'd0);
    rst = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);
    run_cmd(4'd0, 16'h1234, 4'd0, 1'b0);
    run_cmd(4'd1, 16'h0005, 4'd0, 1'b0);
    run_cmd(4'd4, 16'h0000, 4'd0, 1'b0);
    run_cmd(4'd1, 16'h0003, 4'd0, 1'b0);
    run_cmd(4'd0, 16'h0000, 4'd0, 1'b0);
    run_cmd(4'd1, 16'h0001, 4'd0, 1'b0);
    run_cmd(4'd6, 16'h00aa, 4'd3, 1'b0);
    run_cmd(4'd5, 16'h0055, 4'd0, 1'b0);
    run_cmd(4'hc, 16'h0007, 4'd2, 1'b0);
    run_cmd(4'd5, 16'h0000, 4'd15, 1'b0);
    while (!cmd_ready) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 4'd5;
    cmd_count = 4'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("abort_s1", 32'(strb), 32'(10'd1 << 5));
    @(negedge clk);
    chk("abort_s2", 32'(strb), 32'(10'd1 << 5));
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rst", 32'({cmd_ready, br_load, strb, busy, done, err, br_data}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'({cmd_ready, done, busy}), 32'b100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_nodone", 32'({done, strb}), 32'd0);
    end
    run_cmd(4'd0, 16'h0000, 4'd0, 1'b1);
    run_cmd(4'd9, 16'h0000, 4'd0, 1'b1);
    run_cmd(4'd8, 16'h00f0, 4'd0, 1'b0);
    for (int i = 0; i < 40; i++)
      run_cmd(4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0 ? 16'd0 : 16'($urandom),
              4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    run_cmd(4'd2, 16'h0101, 4'd0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
